// File: rtl/groestl512_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// groestl512_core: iterative single-block Groestl-512, one P and one Q round per clock.
// Revision: 1.0
// ---------------------------------------------------------------------------
module groestl512_core (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [647:0] data,
  output logic         ready,
  output logic         done,
  output logic [511:0] hash
);

  localparam logic [2047:0] SBOX = {
    256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [31:0]   SHIFT_P = 32'h0123456B;
  localparam logic [31:0]   SHIFT_Q = 32'h135B0246;
  localparam logic [1023:0] H0      = 1024'h0200;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COMPRESS = 3'd1,
    MERGE    = 3'd2,
    OUTPUT   = 3'd3,
    FINISH   = 3'd4
  } phase_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Coefficient idx of circ(02,02,03,04,05,03,05,07) applied to a.
  function automatic logic [7:0] mul_b(input logic [7:0] a, input logic [2:0] idx);
    logic [7:0] a2;
    logic [7:0] a4;
    a2 = xt(a);
    a4 = xt(a2);
    case (idx)
      3'd0, 3'd1: mul_b = a2;
      3'd2, 3'd5: mul_b = a2 ^ a;
      3'd3:       mul_b = a4;
      3'd4, 3'd6: mul_b = a4 ^ a;
      default:    mul_b = a4 ^ a2 ^ a;
    endcase
  endfunction

  function automatic logic [1023:0] round_f(input logic [1023:0] s, input logic [3:0] r,
                                            input logic is_q);
    logic [7:0]    b [8][16];
    logic [7:0]    acc;
    logic [3:0]    sh;
    logic [1023:0] o;
    o = '0;
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 8; i++) begin
        b[i][j] = s[1023 - 8*(8*j + i) -: 8];
        if (is_q)
          b[i][j] = b[i][j] ^ ((i == 7) ? ~{j[3:0], r} : 8'hff);
        else if (i == 0)
          b[i][j] = b[i][j] ^ {j[3:0], r};
        b[i][j] = sbox(b[i][j]);
      end
    end
    // ShiftBytes folded into the MixBytes column gather.
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 8; i++) begin
        acc = '0;
        for (int k = 0; k < 8; k++) begin
          sh  = is_q ? SHIFT_Q[31 - 4*k -: 4] : SHIFT_P[31 - 4*k -: 4];
          acc = acc ^ mul_b(b[k][4'(j) + sh], 3'(k - i));
        end
        o[1023 - 8*(8*j + i) -: 8] = acc;
      end
    end
    return o;
  endfunction

  logic [1023:0] p_q, q_q;
  logic [3:0]    round_q;
  phase_e        phase_q;
  logic          ready_q, done_q;
  logic [511:0]  hash_q;

  logic [1023:0] msg_d, p_rnd_d, q_rnd_d, x_d;

  assign msg_d   = {data, 312'd0, 64'd1};
  assign p_rnd_d = round_f(p_q, round_q, 1'b0);
  assign q_rnd_d = round_f(q_q, round_q, 1'b1);
  assign x_d     = p_q ^ q_q ^ H0;

  // Q is idle during the output transform, so it holds the chaining value X there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q     <= '0;
      q_q     <= '0;
      round_q <= '0;
      phase_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      hash_q  <= '0;
    end else begin
      case (phase_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            p_q     <= H0 ^ msg_d;
            q_q     <= msg_d;
            round_q <= '0;
            ready_q <= 1'b0;
            phase_q <= COMPRESS;
          end
        end
        COMPRESS: begin
          p_q     <= p_rnd_d;
          q_q     <= q_rnd_d;
          round_q <= round_q + 4'd1;
          if (round_q == 4'd13) phase_q <= MERGE;
        end
        MERGE: begin
          p_q     <= x_d;
          q_q     <= x_d;
          round_q <= '0;
          phase_q <= OUTPUT;
        end
        OUTPUT: begin
          p_q     <= p_rnd_d;
          round_q <= round_q + 4'd1;
          if (round_q == 4'd13) phase_q <= FINISH;
        end
        FINISH: begin
          hash_q  <= p_q[511:0] ^ q_q[511:0];
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          phase_q <= IDLE;
        end
        default: phase_q <= IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign hash  = hash_q;

endmodule
`default_nettype wire

// File: tb/tb_groestl512_core.sv
`default_nettype none
// tb_groestl512_core: directed and random hashes checked every cycle against a
// software Groestl-512 model plus a start-to-done timer.
module tb_groestl512_core;

  localparam logic [511:0] EMPTY_HASH = 512'h6d3ad29d279110eef3adbd66de2a0345a77baede1557f5d099fce0c03d6dc2ba8e6d4a6633dfbd66053c20faa87d1a11f39a7fbe4a6c2f009801370308fc4ad8;
  localparam int SHP [8] = '{0, 1, 2, 3, 4, 5, 6, 11};
  localparam int SHQ [8] = '{1, 3, 5, 11, 0, 2, 4, 6};
  localparam int CB  [8] = '{2, 2, 3, 4, 5, 3, 5, 7};

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [647:0] data  = '0;
  logic         ready, done;
  logic [511:0] hash;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [256];

  groestl512_core dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .ready (ready),
    .done  (done),
    .hash  (hash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [1023:0] perm(input logic [1023:0] v, input bit isq);
    logic [7:0]    a [8][16];
    logic [7:0]    t [8][16];
    logic [7:0]    acc;
    logic [1023:0] o;
    for (int k = 0; k < 128; k++) a[k % 8][k / 8] = v[1023 - 8*k -: 8];
    for (int r = 0; r < 14; r++) begin
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 16; j++) begin
          if (isq) begin
            a[i][j] = a[i][j] ^ 8'hff;
            if (i == 7) a[i][j] = a[i][j] ^ 8'(j * 16 + r);
          end else if (i == 0) begin
            a[i][j] = a[i][j] ^ 8'(j * 16 + r);
          end
          a[i][j] = sb[a[i][j]];
        end
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 16; j++)
          t[i][j] = a[i][(j + (isq ? SHQ[i] : SHP[i])) % 16];
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 16; j++) begin
          acc = 8'h00;
          for (int k = 0; k < 8; k++) acc = acc ^ gm(8'(CB[(k - i + 8) % 8]), t[k][j]);
          a[i][j] = acc;
        end
    end
    for (int k = 0; k < 128; k++) o[1023 - 8*k -: 8] = a[k % 8][k / 8];
    return o;
  endfunction

  function automatic logic [511:0] groestl(input logic [647:0] d);
    logic [1023:0] m, h0, x, y;
    m  = {d, 312'd0, 64'd1};
    h0 = 1024'h0200;
    x  = perm(h0 ^ m, 1'b0) ^ perm(m, 1'b1) ^ h0;
    y  = perm(x, 1'b0) ^ x;
    return y[511:0];
  endfunction

  function automatic logic [647:0] rand_hdr();
    logic [639:0] v;
    for (int i = 0; i < 20; i++) v[i*32 +: 32] = $urandom;
    return {v, 8'h80};
  endfunction

  // Reference: a hash accepted while idle completes 30 edges later.
  logic         m_busy    = 1'b0;
  int           m_cnt     = 0;
  logic [511:0] m_pending = '0;
  logic         exp_ready = 1'b1;
  logic         exp_done  = 1'b0;
  logic [511:0] exp_hash  = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy    <= 1'b0;
      m_cnt     <= 0;
      exp_ready <= 1'b1;
      exp_done  <= 1'b0;
      exp_hash  <= '0;
    end else if (!m_busy) begin
      exp_done <= 1'b0;
      if (start) begin
        m_busy    <= 1'b1;
        m_cnt     <= 1;
        m_pending <= groestl(data);
        exp_ready <= 1'b0;
      end
    end else if (m_cnt == 30) begin
      m_busy    <= 1'b0;
      exp_ready <= 1'b1;
      exp_done  <= 1'b1;
      exp_hash  <= m_pending;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc_ready", 512'(ready), 512'(exp_ready));
      chk("cyc_done", 512'(done), 512'(exp_done));
      chk("cyc_hash", hash, exp_hash);
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", 512'(ready), 512'd1);
  endtask

  // Called at a negedge with ready=1; returns at the negedge where done is seen.
  task automatic run_hash(input logic [647:0] d, output int lat);
    start = 1'b1;
    data  = d;
    @(negedge clk);
    start = 1'b0;
    data  = rand_hdr();
    lat   = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    logic [647:0] empty, hdr, d1, d2, chain;
    logic [511:0] dig, held;
    logic [7:0]   inv, b;
    int           lat, nd, last;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    chk("model_gmul", 512'(gm(8'h57, 8'h83)), 512'h c1);
    chk("model_sbox00", 512'(sb[0]), 512'h63);
    chk("model_sbox53", 512'(sb[8'h53]), 512'hed);
    chk("model_sboxff", 512'(sb[8'hff]), 512'h16);
    empty = {8'h80, 640'd0};
    chk("model_empty", groestl(empty), EMPTY_HASH);

    repeat (3) @(negedge clk);
    chk("por_ready", 512'(ready), 512'd1);
    chk("por_done", 512'(done), 512'd0);
    chk("por_hash", hash, 512'd0);
    reset = 1'b0;

    run_hash(empty, lat);
    chk("empty_latency", 512'(lat), 512'd30);
    chk("empty_hash", hash, EMPTY_HASH);
    @(negedge clk);
    chk("empty_pulse", 512'(done), 512'd0);

    hdr = rand_hdr();
    run_hash(hdr, lat);
    chk("hdr_latency", 512'(lat), 512'd30);
    chk("hdr_hash", hash, groestl(hdr));
    dig = hash;
    @(negedge clk);
    chk("hdr_pulse", 512'(done), 512'd0);
    chain = {dig, 8'h80, 128'd0};
    run_hash(chain, lat);
    chk("chain_latency", 512'(lat), 512'd30);
    chk("chain_hash", hash, groestl(chain));
    @(negedge clk);
    chk("chain_pulse", 512'(done), 512'd0);

    d1 = rand_hdr();
    d2 = rand_hdr();
    start = 1'b1;
    data  = d1;
    @(negedge clk);
    start = 1'b0;
    data  = d2;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_hash", hash, groestl(d1));
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("busy_no_second_done", 512'(nd), 512'd0);

    wait_ready();
    start = 1'b1;
    data  = rand_hdr();
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_ready", 512'(ready), 512'd1);
    chk("rst_done", 512'(done), 512'd0);
    chk("rst_hash", hash, 512'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_hash(empty, lat);
    chk("rst_latency", 512'(lat), 512'd30);
    chk("rst_empty_hash", hash, EMPTY_HASH);

    wait_ready();
    start = 1'b1;
    data  = rand_hdr();
    last  = -1;
    nd    = 0;
    held  = '0;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      data = rand_hdr();
      if (done === 1'b1) begin
        if (last >= 0) chk("b2b_interval", 512'(c - last), 512'd31);
        last = c;
        held = hash;
        nd++;
      end else if (nd > 0) begin
        chk("b2b_hold", hash, held);
      end
    end
    start = 1'b0;
    chk("b2b_pulses", 512'(nd), 512'd4);
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
